// File: rtl/npc_predictor_pkg.sv
// Shared types for the next-PC predictor: resolve type codes, 2-bit counter
// states and the saturating counter update.
package npc_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BLEZ = 4'd3,
        BGTZ = 4'd4,
        BLTZ = 4'd5,
        BGEZ = 4'd6,
        J    = 4'd7,
        JAL  = 4'd8,
        JR   = 4'd9
    } res_type_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != ST)
            res = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            res = ctr - 2'd1;
        return res;
    endfunction

    function automatic logic is_jump(input res_type_e t);
        return (t == J) || (t == JAL) || (t == JR);
    endfunction

endpackage

// File: rtl/npc_predictor_if.sv
// Fetch/resolve bundle of the next-PC predictor. The master side drives
// control and resolve information; the slave side is the predictor.
interface npc_predictor_if #(
    parameter int PC_W = 32
);
    import npc_pkg::*;

    logic            halt;
    logic            stall;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            res_valid;
    logic [PC_W-1:0] res_pc;
    res_type_e       res_type;
    logic            res_eq;
    logic            res_a_sign;
    logic            res_a_zero;
    logic [PC_W-1:0] res_target;
    logic            res_pred_taken;
    logic [PC_W-1:0] res_pred_target;
    logic            flush;
    logic [31:0]     cnt_ctrl;
    logic [31:0]     cnt_mispred;

    modport master (
        output halt, stall, res_valid, res_pc, res_type, res_eq, res_a_sign,
               res_a_zero, res_target, res_pred_taken, res_pred_target,
        input  pc, pred_taken, pred_target, flush, cnt_ctrl, cnt_mispred
    );

    modport slave (
        input  halt, stall, res_valid, res_pc, res_type, res_eq, res_a_sign,
               res_a_zero, res_target, res_pred_taken, res_pred_target,
        output pc, pred_taken, pred_target, flush, cnt_ctrl, cnt_mispred
    );

endinterface

// File: rtl/npc_predictor_branch_target_table.sv
// Direct-mapped branch target table: two asynchronous read ports (fetch and
// resolve), one synchronous write port, asynchronous clear.
module branch_target_table
    import npc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 28,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] fetch_idx,
    output logic             fetch_valid,
    output logic [TAG_W-1:0] fetch_tag,
    output logic [PC_W-1:0]  fetch_target,
    output logic [1:0]       fetch_ctr,
    input  logic [IDX_W-1:0] res_idx,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [PC_W-1:0]  res_target,
    output logic [1:0]       res_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [1:0]       wr_ctr
);

    logic [DEPTH-1:0] valid_reg;
    logic [TAG_W-1:0] tag_reg    [DEPTH];
    logic [PC_W-1:0]  target_reg [DEPTH];
    logic [1:0]       ctr_reg    [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= WNT;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    valid_reg[i]  <= 1'b1;
                    tag_reg[i]    <= wr_tag;
                    target_reg[i] <= wr_target;
                    ctr_reg[i]    <= wr_ctr;
                end
            end
        end
    end

    // Reads see the pre-write contents; a write lands on the next edge.
    assign fetch_valid  = valid_reg[fetch_idx];
    assign fetch_tag    = tag_reg[fetch_idx];
    assign fetch_target = target_reg[fetch_idx];
    assign fetch_ctr    = ctr_reg[fetch_idx];

    assign res_valid  = valid_reg[res_idx];
    assign res_tag    = tag_reg[res_idx];
    assign res_target = target_reg[res_idx];
    assign res_ctr    = ctr_reg[res_idx];

endmodule

// File: rtl/npc_predictor.sv
// Next-PC generator: fetch PC register, same-cycle table prediction, branch
// resolution with table training, mispredict redirect and event counters.
module npc_predictor
    import npc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              BTT_DEPTH = 16,
    parameter int              PC_STEP   = 1,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    npc_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(BTT_DEPTH);
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [31:0]      cnt_ctrl_reg, cnt_mispred_reg;

    logic             f_valid, r_valid;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic [PC_W-1:0]  f_target, r_target;
    logic [1:0]       f_ctr, r_ctr;

    logic             act_taken, res_active, mispred, flush_int, upd_en, res_hit;
    logic             wr_en;
    logic [PC_W-1:0]  wr_target;
    logic [1:0]       wr_ctr;
    logic             pred_taken_int;

    branch_target_table #(
        .DEPTH (BTT_DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .PC_W  (PC_W)
    ) u_btt (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_idx    (pc_reg[IDX_W-1:0]),
        .fetch_valid  (f_valid),
        .fetch_tag    (f_tag),
        .fetch_target (f_target),
        .fetch_ctr    (f_ctr),
        .res_idx      (bus.res_pc[IDX_W-1:0]),
        .res_valid    (r_valid),
        .res_tag      (r_tag),
        .res_target   (r_target),
        .res_ctr      (r_ctr),
        .wr_en        (wr_en),
        .wr_idx       (bus.res_pc[IDX_W-1:0]),
        .wr_tag       (bus.res_pc[PC_W-1:IDX_W]),
        .wr_target    (wr_target),
        .wr_ctr       (wr_ctr)
    );

    assign pred_taken_int = f_valid && (f_tag == pc_reg[PC_W-1:IDX_W]) && f_ctr[1];

    always_comb begin
        act_taken = 1'b0;
        case (bus.res_type)
            BEQ:         act_taken = bus.res_eq;
            BNE:         act_taken = !bus.res_eq;
            BLEZ:        act_taken = bus.res_a_sign || bus.res_a_zero;
            BGTZ:        act_taken = !bus.res_a_sign && !bus.res_a_zero;
            BLTZ:        act_taken = bus.res_a_sign;
            BGEZ:        act_taken = !bus.res_a_sign;
            J, JAL, JR:  act_taken = 1'b1;
            default:     act_taken = 1'b0;
        endcase
    end

    // A NONE type never counts as resolving, even with res_valid high.
    assign res_active = bus.res_valid && (bus.res_type != NONE);
    assign mispred    = res_active &&
                        ((act_taken != bus.res_pred_taken) ||
                         (act_taken && (bus.res_target != bus.res_pred_target)));
    assign flush_int  = mispred && !bus.halt && rst_n;
    assign upd_en     = res_active && !bus.halt;
    assign res_hit    = r_valid && (r_tag == bus.res_pc[PC_W-1:IDX_W]);

    // Misses allocate only when taken; hits always train.
    always_comb begin
        wr_en     = upd_en && (res_hit || act_taken);
        wr_target = act_taken ? bus.res_target : r_target;
        if (!res_hit)
            wr_ctr = is_jump(bus.res_type) ? ST : WT;
        else if (is_jump(bus.res_type))
            wr_ctr = ST;
        else
            wr_ctr = ctr_update(r_ctr, act_taken);
    end

    always_comb begin
        pc_next = pc_reg + STEP;
        if (bus.halt)
            pc_next = pc_reg;
        else if (flush_int)
            pc_next = act_taken ? bus.res_target : bus.res_pc + STEP;
        else if (bus.stall)
            pc_next = pc_reg;
        else if (pred_taken_int)
            pc_next = f_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            cnt_ctrl_reg    <= '0;
            cnt_mispred_reg <= '0;
        end else begin
            pc_reg <= pc_next;
            if (upd_en && cnt_ctrl_reg != 32'hFFFF_FFFF)
                cnt_ctrl_reg <= cnt_ctrl_reg + 32'd1;
            if (flush_int && cnt_mispred_reg != 32'hFFFF_FFFF)
                cnt_mispred_reg <= cnt_mispred_reg + 32'd1;
        end
    end

    assign bus.pc          = pc_reg;
    assign bus.pred_taken  = pred_taken_int;
    assign bus.pred_target = f_target;
    assign bus.flush       = flush_int;
    assign bus.cnt_ctrl    = cnt_ctrl_reg;
    assign bus.cnt_mispred = cnt_mispred_reg;

endmodule
